rx_ltssm: RTL and testbench

Receive-side LTSSM companion to the TX LTSSM. It follows the state commanded by the main LTSSM and watches the ordered-set decoder output. It counts qualifying consecutive TS1/TS2/IDLE ordered sets, applies the Polling/Configuration timeout, and reports the required exit to the main LTSSM with a finish pulse. On the upstream device it also captures the link number proposed by the partner.

---
 rtl/rx_ltssm_pkg.sv | 37 +++
 rtl/rx_ltssm_if.sv | 28 ++
 rtl/rx_ltssm_os_consec_counter.sv | 48 ++++
 rtl/rx_ltssm.sv | 147 ++++++++++++++
 tb/tb_rx_ltssm.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rx_ltssm_pkg.sv
// Shared LTSSM definitions: state encodings (common with the TX LTSSM),
// ordered-set type codes, PAD symbol and consecutive-OS thresholds.
package ltssm_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET   = 4'b0000,
    DETECT_ACTIVE  = 4'b0001,
    POLLING_ACTIVE = 4'b0010,
    POLLING_CONFIG = 4'b0011,
    CFG_LW_START   = 4'b0100,
    CFG_LW_ACCEPT  = 4'b0101,
    CFG_LN_WAIT    = 4'b0110,
    CFG_LN_ACTIVE  = 4'b0111,
    CFG_COMPLETE   = 4'b1000,
    CFG_IDLE       = 4'b1001,
    L0             = 4'b1010,
    IDLE           = 4'b1111
  } ltssm_state_e;

  typedef enum logic [1:0] {
    OS_TS1   = 2'b00,
    OS_TS2   = 2'b01,
    OS_IDLE  = 2'b10,
    OS_OTHER = 2'b11
  } os_type_e;

  localparam logic [7:0] PAD_SYM      = 8'hF7;
  localparam logic [3:0] THRESH_LONG  = 4'd8;
  localparam logic [3:0] THRESH_SHORT = 4'd2;

  // States guarded by the Polling/Configuration timeout.
  function automatic logic is_timed(ltssm_state_e s);
    return s inside {POLLING_ACTIVE, POLLING_CONFIG, CFG_LW_START, CFG_LW_ACCEPT,
                     CFG_LN_WAIT, CFG_LN_ACTIVE, CFG_COMPLETE, CFG_IDLE};
  endfunction

endpackage

// File: rtl/rx_ltssm_if.sv
// Bundle between the main LTSSM / OS decoder (master) and the RX LTSSM (slave).
interface rx_ltssm_if
  import ltssm_pkg::*;
#(
  parameter int unsigned LANESNUMBER = 16
);
  ltssm_state_e           SetRXState;
  logic                   RXFinishFlag;
  ltssm_state_e           RXExitTo;
  logic                   OSValid;
  os_type_e               OSType;
  logic [7:0]             RxLinkNum;
  logic [7:0]             RxLaneNum;
  logic [LANESNUMBER-1:0] RxLaneValid;
  logic [7:0]             ReadLinkNum;
  logic [7:0]             WriteLinkNum;
  logic                   WriteLinkNumFlag;

  modport master (
    output SetRXState, OSValid, OSType, RxLinkNum, RxLaneNum, RxLaneValid, ReadLinkNum,
    input  RXFinishFlag, RXExitTo, WriteLinkNum, WriteLinkNumFlag
  );

  modport slave (
    input  SetRXState, OSValid, OSType, RxLinkNum, RxLaneNum, RxLaneValid, ReadLinkNum,
    output RXFinishFlag, RXExitTo, WriteLinkNum, WriteLinkNumFlag
  );
endinterface

// File: rtl/rx_ltssm_os_consec_counter.sv
// Consecutive qualifying ordered-set counter: saturates at 15, clears on a
// non-qualifying OS, flags the threshold crossing once until cleared.
module os_consec_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       valid_i,
  input  logic       qualify_i,
  input  logic [3:0] threshold_i,
  input  logic       force_done_i,
  output logic       hit_o,
  output logic       done_o
);
  logic [3:0] count_q, count_d;
  logic       done_q, done_d;
  logic [4:0] count_inc;

  assign count_inc = {1'b0, count_q} + 5'd1;
  assign done_o    = done_q;

  always_comb begin
    hit_o   = !clear_i && valid_i && qualify_i && !done_q &&
              (count_inc == {1'b0, threshold_i});
    count_d = count_q;
    done_d  = done_q;
    if (clear_i) begin
      count_d = '0;
      done_d  = 1'b0;
    end else begin
      if (valid_i) begin
        count_d = qualify_i ? (count_inc[4] ? 4'hF : count_inc[3:0]) : '0;
      end
      if (hit_o || force_done_i) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: rtl/rx_ltssm.sv
// RX LTSSM: tracks the commanded state, counts qualifying ordered sets,
// applies the Polling/Config timeout and reports the exit with a one-cycle pulse.
module rx_ltssm
  import ltssm_pkg::*;
#(
  parameter int unsigned DEVICETYPE     = 0,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd6000000,
  parameter logic [7:0]  PAD            = PAD_SYM
) (
  input logic       Pclk,
  input logic       Reset,
  rx_ltssm_if.slave bus
);
  localparam bit UPSTREAM = (DEVICETYPE == 32'd1);

  ltssm_state_e state_q;
  logic         changed;

  logic         os_vld_q;
  os_type_e     os_type_q;
  logic [7:0]   os_link_q, os_lane_q;

  logic [23:0]  to_q, to_d;
  logic         timed, to_fire;

  logic         counting, qualify, capture;
  logic [3:0]   threshold;
  ltssm_state_e target;
  logic         os_hit, done;

  logic         finish_q, wflag_q;
  ltssm_state_e exit_q;
  logic [7:0]   wlink_q;

  logic link_pad, lane_pad, link_rd, is_ts1, is_ts2;

  assign changed  = (bus.SetRXState != state_q);
  assign link_pad = (os_link_q == PAD);
  assign lane_pad = (os_lane_q == PAD);
  assign link_rd  = (os_link_q == bus.ReadLinkNum);
  assign is_ts1   = (os_type_q == OS_TS1);
  assign is_ts2   = (os_type_q == OS_TS2);

  always_comb begin
    counting  = 1'b1;
    qualify   = 1'b0;
    capture   = 1'b0;
    threshold = THRESH_LONG;
    target    = DETECT_QUIET;
    case (state_q)
      POLLING_ACTIVE: begin
        qualify = (is_ts1 || is_ts2) && link_pad && lane_pad;
        target  = POLLING_CONFIG;
      end
      POLLING_CONFIG: begin
        qualify = is_ts2 && link_pad && lane_pad;
        target  = CFG_LW_START;
      end
      CFG_LW_START: begin
        qualify   = is_ts1 && !link_pad && (UPSTREAM || link_rd);
        capture   = UPSTREAM;
        threshold = THRESH_SHORT;
        target    = CFG_LW_ACCEPT;
      end
      CFG_LW_ACCEPT: begin
        counting  = UPSTREAM;
        qualify   = is_ts1 && link_rd && !lane_pad;
        threshold = THRESH_SHORT;
        target    = CFG_LN_WAIT;
      end
      CFG_LN_WAIT: begin
        qualify   = is_ts1 && link_rd && !lane_pad;
        threshold = THRESH_SHORT;
        target    = CFG_LN_ACTIVE;
      end
      CFG_LN_ACTIVE: begin
        qualify   = is_ts2 && link_rd;
        threshold = THRESH_SHORT;
        target    = CFG_COMPLETE;
      end
      CFG_COMPLETE: begin
        qualify = is_ts2 && link_rd && !lane_pad;
        target  = CFG_IDLE;
      end
      CFG_IDLE: begin
        qualify = (os_type_q == OS_IDLE);
        target  = L0;
      end
      default: counting = 1'b0;
    endcase
  end

  assign timed   = is_timed(state_q);
  assign to_d    = (changed || !timed) ? '0 : to_q + 24'd1;
  assign to_fire = timed && !changed && !done && (to_q == TIMEOUT_CYCLES - 24'd1);

  // The counter evaluates the OS registered one cycle earlier; an OS offered
  // in a state-change cycle never enters that register.
  os_consec_counter u_cnt (
    .clk_i        (Pclk),
    .rst_ni       (Reset),
    .clear_i      (changed),
    .valid_i      (os_vld_q && counting),
    .qualify_i    (qualify),
    .threshold_i  (threshold),
    .force_done_i (to_fire),
    .hit_o        (os_hit),
    .done_o       (done)
  );

  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      os_vld_q  <= 1'b0;
      os_type_q <= OS_TS1;
      os_link_q <= '0;
      os_lane_q <= '0;
      to_q      <= '0;
      finish_q  <= 1'b0;
      exit_q    <= DETECT_QUIET;
      wflag_q   <= 1'b0;
      wlink_q   <= '0;
    end else begin
      state_q   <= bus.SetRXState;
      os_vld_q  <= bus.OSValid && !changed;
      os_type_q <= bus.OSType;
      os_link_q <= bus.RxLinkNum;
      os_lane_q <= bus.RxLaneNum;
      to_q      <= to_d;
      finish_q  <= os_hit || to_fire;
      if (os_hit) begin
        exit_q <= target;
      end else if (to_fire) begin
        exit_q <= DETECT_QUIET;
      end
      wflag_q <= os_hit && capture;
      if (os_hit && capture) begin
        wlink_q <= os_link_q;
      end
    end
  end

  assign bus.RXFinishFlag     = finish_q;
  assign bus.RXExitTo         = exit_q;
  assign bus.WriteLinkNum     = wlink_q;
  assign bus.WriteLinkNumFlag = wflag_q;
endmodule

// File: tb/tb_rx_ltssm.sv
// Directed bench for rx_ltssm: one downstream and one upstream instance share
// the same stimulus; a per-cycle vector table plus reset and timeout sequences.
module tb_rx_ltssm;
  import ltssm_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rx_ltssm_if #(.LANESNUMBER(16)) bus_dn ();
  rx_ltssm_if #(.LANESNUMBER(16)) bus_up ();

  rx_ltssm #(.DEVICETYPE(0), .TIMEOUT_CYCLES(24'd100), .PAD(8'hF7)) dut_dn (
    .Pclk (clk), .Reset (rst_n), .bus (bus_dn)
  );
  rx_ltssm #(.DEVICETYPE(1), .TIMEOUT_CYCLES(24'd100), .PAD(8'hF7)) dut_up (
    .Pclk (clk), .Reset (rst_n), .bus (bus_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    ltssm_state_e st;
    logic         v;
    os_type_e     t;
    logic [7:0]   lk;
    logic [7:0]   ln;
    logic         fin_dn;
    logic         fin_up;
    ltssm_state_e ex;
    logic         wf_up;
    logic [7:0]   wl;
    ltssm_state_e ex_dn;
    ltssm_state_e ex_up;
    logic [7:0]   wl_up;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(ltssm_state_e st, logic v, os_type_e t,
                              logic [7:0] lk, logic [7:0] ln, int unsigned n);
    vec_t e;
    e.st = st; e.v = v; e.t = t; e.lk = lk; e.ln = ln;
    e.fin_dn = 1'b0; e.fin_up = 1'b0; e.ex = DETECT_QUIET; e.wf_up = 1'b0; e.wl = '0;
    e.ex_dn = DETECT_QUIET; e.ex_up = DETECT_QUIET; e.wl_up = '0;
    for (int unsigned k = 0; k < n; k++) tbl.push_back(e);
  endfunction

  function automatic void pulse(int unsigned idx, logic d, logic u, ltssm_state_e ex,
                                logic wf, logic [7:0] wl);
    tbl[idx].fin_dn = d;
    tbl[idx].fin_up = u;
    tbl[idx].ex     = ex;
    tbl[idx].wf_up  = wf;
    tbl[idx].wl     = wl;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(ltssm_state_e st, logic v, os_type_e t, logic [7:0] lk, logic [7:0] ln);
    bus_dn.SetRXState = st; bus_dn.OSValid = v; bus_dn.OSType = t;
    bus_dn.RxLinkNum = lk;  bus_dn.RxLaneNum = ln;
    bus_up.SetRXState = st; bus_up.OSValid = v; bus_up.OSType = t;
    bus_up.RxLinkNum = lk;  bus_up.RxLaneNum = ln;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " fin_dn"}, {7'd0, bus_dn.RXFinishFlag}, 8'd0);
    chk({tag, " exit_dn"}, {4'd0, bus_dn.RXExitTo}, 8'd0);
    chk({tag, " wl_dn"}, bus_dn.WriteLinkNum, 8'd0);
    chk({tag, " wf_dn"}, {7'd0, bus_dn.WriteLinkNumFlag}, 8'd0);
    chk({tag, " fin_up"}, {7'd0, bus_up.RXFinishFlag}, 8'd0);
    chk({tag, " exit_up"}, {4'd0, bus_up.RXExitTo}, 8'd0);
    chk({tag, " wl_up"}, bus_up.WriteLinkNum, 8'd0);
    chk({tag, " wf_up"}, {7'd0, bus_up.WriteLinkNumFlag}, 8'd0);
  endtask

  initial begin
    int unsigned  b;
    logic [11:0]  pat;
    ltssm_state_e hold_dn, hold_up;
    logic [7:0]   hold_wl;
    int           first_dn, first_up, npulse_dn, npulse_up;

    checks = 0;
    failures = 0;

    // Polling pass: 8 TS1 with PAD link/lane.
    b = tbl.size();
    add(POLLING_ACTIVE, 1'b0, OS_OTHER, 8'h00, 8'h00, 1);
    add(POLLING_ACTIVE, 1'b1, OS_TS1, PAD_SYM, PAD_SYM, 8);
    add(POLLING_ACTIVE, 1'b0, OS_OTHER, 8'h00, 8'h00, 3);
    pulse(b + 10, 1'b1, 1'b1, POLLING_CONFIG, 1'b0, 8'h00);
    // Broken streak: 5 TS2, TS1, 8 TS2.
    b = tbl.size();
    add(POLLING_CONFIG, 1'b0, OS_OTHER, 8'h00, 8'h00, 1);
    add(POLLING_CONFIG, 1'b1, OS_TS2, PAD_SYM, PAD_SYM, 5);
    add(POLLING_CONFIG, 1'b1, OS_TS1, PAD_SYM, PAD_SYM, 1);
    add(POLLING_CONFIG, 1'b1, OS_TS2, PAD_SYM, PAD_SYM, 8);
    add(POLLING_CONFIG, 1'b0, OS_OTHER, 8'h00, 8'h00, 3);
    pulse(b + 16, 1'b1, 1'b1, CFG_LW_START, 1'b0, 8'h00);
    // LinkWidthStart: link 02 counts only upstream; link 01 matches ReadLinkNum.
    b = tbl.size();
    add(CFG_LW_START, 1'b0, OS_OTHER, 8'h00, 8'h00, 1);
    add(CFG_LW_START, 1'b1, OS_TS1, 8'h02, PAD_SYM, 1);
    add(CFG_LW_START, 1'b1, OS_TS1, 8'h01, PAD_SYM, 2);
    add(CFG_LW_START, 1'b0, OS_OTHER, 8'h00, 8'h00, 3);
    pulse(b + 4, 1'b0, 1'b1, CFG_LW_ACCEPT, 1'b1, 8'h01);
    pulse(b + 5, 1'b1, 1'b0, CFG_LW_ACCEPT, 1'b0, 8'h00);
    // LinkWidthAccept exits only on the upstream side.
    b = tbl.size();
    add(CFG_LW_ACCEPT, 1'b0, OS_OTHER, 8'h00, 8'h00, 1);
    add(CFG_LW_ACCEPT, 1'b1, OS_TS1, 8'h01, 8'h00, 2);
    add(CFG_LW_ACCEPT, 1'b0, OS_OTHER, 8'h00, 8'h00, 3);
    pulse(b + 4, 1'b0, 1'b1, CFG_LN_WAIT, 1'b0, 8'h00);
    // ConfigrationIdle: 8 IDLE with gaps.
    b = tbl.size();
    add(CFG_IDLE, 1'b0, OS_OTHER, 8'h00, 8'h00, 1);
    pat = 12'b1010_1101_1011;
    for (int k = 11; k >= 0; k--) add(CFG_IDLE, pat[k], OS_IDLE, PAD_SYM, PAD_SYM, 1);
    add(CFG_IDLE, 1'b0, OS_OTHER, 8'h00, 8'h00, 3);
    pulse(b + 14, 1'b1, 1'b1, L0, 1'b0, 8'h00);
    // TS1 in the change cycle is discarded: 7 more do not finish, 8th does.
    b = tbl.size();
    add(POLLING_ACTIVE, 1'b1, OS_TS1, PAD_SYM, PAD_SYM, 8);
    add(POLLING_ACTIVE, 1'b0, OS_OTHER, 8'h00, 8'h00, 3);
    add(POLLING_ACTIVE, 1'b1, OS_TS1, PAD_SYM, PAD_SYM, 1);
    add(POLLING_ACTIVE, 1'b0, OS_OTHER, 8'h00, 8'h00, 3);
    pulse(b + 13, 1'b1, 1'b1, POLLING_CONFIG, 1'b0, 8'h00);
    // L0 entered alongside an IDLE: no exits in L0.
    add(L0, 1'b1, OS_IDLE, PAD_SYM, PAD_SYM, 1);
    add(L0, 1'b0, OS_OTHER, 8'h00, 8'h00, 2);

    hold_dn = DETECT_QUIET;
    hold_up = DETECT_QUIET;
    hold_wl = '0;
    foreach (tbl[i]) begin
      if (tbl[i].fin_dn) hold_dn = tbl[i].ex;
      if (tbl[i].fin_up) hold_up = tbl[i].ex;
      if (tbl[i].wf_up)  hold_wl = tbl[i].wl;
      tbl[i].ex_dn = hold_dn;
      tbl[i].ex_up = hold_up;
      tbl[i].wl_up = hold_wl;
    end

    rst_n = 1'b1;
    drive(IDLE, 1'b0, OS_OTHER, 8'h00, 8'h00);
    bus_dn.RxLaneValid = '1; bus_dn.ReadLinkNum = 8'h01;
    bus_up.RxLaneValid = '1; bus_up.ReadLinkNum = 8'h01;
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("r%0d fin_dn", i), {7'd0, bus_dn.RXFinishFlag}, {7'd0, tbl[i].fin_dn});
      chk($sformatf("r%0d exit_dn", i), {4'd0, bus_dn.RXExitTo}, {4'd0, tbl[i].ex_dn});
      chk($sformatf("r%0d wf_dn", i), {7'd0, bus_dn.WriteLinkNumFlag}, 8'd0);
      chk($sformatf("r%0d wl_dn", i), bus_dn.WriteLinkNum, 8'd0);
      chk($sformatf("r%0d fin_up", i), {7'd0, bus_up.RXFinishFlag}, {7'd0, tbl[i].fin_up});
      chk($sformatf("r%0d exit_up", i), {4'd0, bus_up.RXExitTo}, {4'd0, tbl[i].ex_up});
      chk($sformatf("r%0d wf_up", i), {7'd0, bus_up.WriteLinkNumFlag}, {7'd0, tbl[i].wf_up});
      chk($sformatf("r%0d wl_up", i), bus_up.WriteLinkNum, tbl[i].wl_up);
      drive(tbl[i].st, tbl[i].v, tbl[i].t, tbl[i].lk, tbl[i].ln);
    end

    // Reset after 6 of 8 TS1: immediate return to reset values.
    @(negedge clk);
    drive(POLLING_ACTIVE, 1'b0, OS_OTHER, 8'h00, 8'h00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(POLLING_ACTIVE, 1'b1, OS_TS1, PAD_SYM, PAD_SYM);
    end
    @(negedge clk);
    drive(POLLING_ACTIVE, 1'b0, OS_OTHER, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("postrst ts%0d fin_dn", k), {7'd0, bus_dn.RXFinishFlag}, 8'd0);
      drive(POLLING_ACTIVE, 1'b1, OS_TS1, PAD_SYM, PAD_SYM);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("postrst gap%0d fin_dn", k), {7'd0, bus_dn.RXFinishFlag}, 8'd0);
      drive(POLLING_ACTIVE, 1'b0, OS_OTHER, 8'h00, 8'h00);
    end
    @(negedge clk);
    drive(POLLING_ACTIVE, 1'b1, OS_TS1, PAD_SYM, PAD_SYM);
    @(negedge clk);
    chk("postrst early fin_dn", {7'd0, bus_dn.RXFinishFlag}, 8'd0);
    drive(POLLING_ACTIVE, 1'b0, OS_OTHER, 8'h00, 8'h00);
    @(negedge clk);
    chk("postrst fin_dn", {7'd0, bus_dn.RXFinishFlag}, 8'd1);
    chk("postrst exit_dn", {4'd0, bus_dn.RXExitTo}, {4'd0, POLLING_CONFIG});
    chk("postrst fin_up", {7'd0, bus_up.RXFinishFlag}, 8'd1);

    // Timeout in ConfigrationComplete with no OS: single pulse 100 cycles on.
    @(negedge clk);
    drive(CFG_COMPLETE, 1'b0, OS_OTHER, 8'h00, 8'h00);
    first_dn = -1; first_up = -1; npulse_dn = 0; npulse_up = 0;
    for (int k = 0; k < 250; k++) begin
      @(posedge clk);
      #1;
      if (bus_dn.RXFinishFlag) begin
        if (first_dn < 0) first_dn = k;
        npulse_dn++;
      end
      if (bus_up.RXFinishFlag) begin
        if (first_up < 0) first_up = k;
        npulse_up++;
      end
    end
    chk("timeout first_dn", first_dn[7:0], 8'd100);
    chk("timeout first_up", first_up[7:0], 8'd100);
    chk("timeout npulse_dn", npulse_dn[7:0], 8'd1);
    chk("timeout npulse_up", npulse_up[7:0], 8'd1);
    chk("timeout exit_dn", {4'd0, bus_dn.RXExitTo}, {4'd0, DETECT_QUIET});
    chk("timeout exit_up", {4'd0, bus_up.RXExitTo}, {4'd0, DETECT_QUIET});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
